// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and control FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH steps, low WIDTH product bits.
module alu_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step_s;

    // done and product are combinational so the top can leave BUSY on the last step edge
    assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done       = busy_q && (cnt_q == LAST_CNT);
    assign product    = acc_step_s;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = (cnt_q != LAST_CNT);
        end else begin
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL, valid/ready on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res_s;
    logic [SW-1:0]    sh_s;
    logic             accept_s, is_mul_s, mul_start_s, mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;

    assign sh_s        = b[SW-1:0];
    assign accept_s    = in_valid && (state_q == IDLE);
    assign is_mul_s    = (alu_op == OP_MUL);
    assign mul_start_s = accept_s && is_mul_s;

    always_comb begin
        alu_res_s = '0;
        case (alu_op)
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_ADD:  alu_res_s = a + b;
            OP_SUB:  alu_res_s = a - b;
            OP_NOR:  alu_res_s = ~(a | b);
            OP_SLL:  alu_res_s = a << sh_s;
            OP_SRL:  alu_res_s = a >> sh_s;
            OP_SRA:  alu_res_s = $unsigned($signed(a) >>> sh_s);
            default: alu_res_s = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = BUSY;
                end else if (accept_s) begin
                    state_d  = DONE;
                    result_d = alu_res_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mul_done_s) begin
                    state_d  = DONE;
                    result_d = mul_prod_s;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // No bypass: a new op is only taken from IDLE, even while the result is being drained
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign result = result_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=64): directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t       vecs[16];
    logic [3:0] op_tab[11];

    alu_mc #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        int           sh;
        logic [127:0] wide;
        logic [63:0]  ones;
        sh   = int'(y % 64);
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b1100: return ~(x | y);
            4'b1000: return x << sh;
            4'b1001: return x >> sh;
            4'b1010: return (x >> sh) | (x[63] ? ~(ones >> sh) : 64'h0);
            4'b0011: begin
                wide = {64'h0, x} * {64'h0, y};
                return wide[63:0];
            end
            default: return 64'h0;
        endcase
    endfunction

    // Offer one op, then count edges (accept edge = 1) until out_valid is seen.
    task automatic do_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic z, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_op", {63'h0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        alu_op   = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        alu_op   = 4'b0010;
        lat      = 1;
        guard    = 0;
        while (!out_valid && guard < 200) begin
            @(posedge clk);
            #1;
            lat++;
            guard++;
        end
        r = result;
        z = zero;
    endtask

    initial begin
        logic [63:0] r;
        logic        z;
        int          lat;
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;

        vecs[0]  = '{"add_5_7",   4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1};
        vecs[1]  = '{"sub_eq",    4'b0110, 64'd3, 64'd3, 64'd0, 1'b1, 1};
        vecs[2]  = '{"sub_wrap",  4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
        vecs[3]  = '{"srl_1",     4'b1001, 64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 1'b0, 1};
        vecs[4]  = '{"sra_1",     4'b1010, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000, 1'b0, 1};
        vecs[5]  = '{"sll_63",    4'b1000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1};
        vecs[6]  = '{"and",       4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1};
        vecs[7]  = '{"or",        4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1};
        vecs[8]  = '{"nor_zero",  4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
        vecs[9]  = '{"nor_ones",  4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1};
        vecs[10] = '{"mul_big",   4'b0011, 64'h1_0000_0001, 64'h1_0000_0003, 64'h4_0000_0003, 1'b0, 65};
        vecs[11] = '{"add_wrap",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1};
        vecs[12] = '{"illegal_7", 4'b0111, 64'd9, 64'd9, 64'd0, 1'b1, 1};
        vecs[13] = '{"mul_zero",  4'b0011, 64'd0, 64'h1234_5678, 64'd0, 1'b1, 65};
        vecs[14] = '{"sra_63",    4'b1010, 64'h8000_0000_0000_0000, 64'h3F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1};
        vecs[15] = '{"sll_amt0",  4'b1000, 64'd1, 64'd64, 64'd1, 1'b0, 1};

        op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000,
                   4'b1001, 4'b1010, 4'b0011, 4'b0100, 4'b1111};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 64'h0;
        b         = 64'h0;
        alu_op    = 4'b0000;
        #12;
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero", {63'h0, zero}, 64'd1);
        check("rst_in_ready", {63'h0, in_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].x, vecs[i].y, r, z, lat);
            check({vecs[i].name, "_result"}, r, vecs[i].res);
            check({vecs[i].name, "_zero"}, {63'h0, z}, {63'h0, vecs[i].z});
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            @(posedge clk);
            #1;
            check({vecs[i].name, "_ready_after"}, {62'h0, in_ready, out_valid}, 64'd2);
        end

        // MUL with in_valid pulses while BUSY: they must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'h1_0000_0001;
        b        = 64'h1_0000_0003;
        alu_op   = 4'b0011;
        @(posedge clk);
        #1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            check("busy_in_ready_low", {63'h0, in_ready}, 64'd0);
            in_valid = 1'($urandom);
            alu_op   = 4'b0010;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("mul_pulse_latency", 64'(lat), 64'd65);
        check("mul_pulse_result", result, 64'h4_0000_0003);
        @(posedge clk);
        #1;
        check("mul_pulse_idle", {62'h0, in_ready, out_valid}, 64'd2);

        // Illegal op under backpressure: result held for 10 cycles
        out_ready = 1'b0;
        do_op(4'b0100, 64'h55, 64'hAA, r, z, lat);
        check("bp_latency", 64'(lat), 64'd1);
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {result, zero, out_valid, in_ready} , {64'd0, 1'b1, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", {62'h0, in_ready, out_valid}, 64'd2);

        // Reset 20 cycles into BUSY aborts the MUL
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'd7;
        b        = 64'd9;
        alu_op   = 4'b0011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_busy", {62'h0, in_ready, out_valid}, 64'd0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_zero", {63'h0, zero}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        a        = 64'd1;
        b        = 64'd1;
        alu_op   = 4'b0010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_valid", {63'h0, out_valid}, 64'd1);
        check("post_rst_result", result, 64'd2);
        @(posedge clk);
        #1;

        // Random ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op = op_tab[$urandom_range(0, 10)];
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            if (n % 7 == 3) y = 64'($urandom_range(0, 127));
            do_op(op, x, y, r, z, lat);
            check("rand_result", r, ref_alu(op, x, y));
            check("rand_zero", {63'h0, z}, {63'h0, (ref_alu(op, x, y) == 64'h0)});
            check("rand_latency", 64'(lat), (op == 4'b0011) ? 64'd65 : 64'd1);
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 64, operand and result width in bits; legal values are powers of two from 8 to 128.
REQ-002 The block SHALL have the ports below, one per line.
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  an operation is offered.
- in_ready  output  1  the block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; for shifts, the amount is b[$clog2(WIDTH)-1:0].
- alu_op  input  4  operation select.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  the consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  high exactly when result equals 0.

Function
REQ-003 The op encodings SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 1100 NOR; 1000 SLL; 1001 SRL; 1010 SRA; 0011 MUL (low WIDTH bits of a*b, unsigned).
REQ-004 Any other alu_op value SHALL produce result = 0 and zero = 1 with single-op latency.
REQ-005 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-006 Shifts SHALL use only the low $clog2(WIDTH) bits of b; SRA SHALL replicate a[WIDTH-1].
REQ-007 The control FSM SHALL have three states:
- IDLE: in_ready = 1.
- BUSY: multiply in progress; in_ready = 0, out_valid = 0.
- DONE: out_valid = 1, in_ready = 0.
REQ-008 An operation SHALL be accepted on a rising edge where in_valid && in_ready; a, b and alu_op SHALL be captured on that edge, and later input changes SHALL be ignored.
REQ-009 On acceptance of a non-MUL op, the FSM SHALL go IDLE->DONE, with out_valid high in the cycle after acceptance (latency 1).
REQ-010 On acceptance of MUL, the FSM SHALL go IDLE->BUSY and run a shift-add loop, one multiplier bit per cycle, using a counter from 0 to WIDTH-1.
REQ-011 After WIDTH BUSY cycles the FSM SHALL go BUSY->DONE; out_valid SHALL first be high WIDTH+1 cycles after acceptance.
REQ-012 In DONE, result and zero SHALL be registered and stable until the edge where out_valid && out_ready; on that edge the FSM SHALL go DONE->IDLE.
REQ-013 There SHALL be no same-cycle bypass: in_ready is low in DONE even when out_ready = 1, so peak throughput is one op every 2 cycles.
REQ-014 zero SHALL be computed from the registered result, never from the raw operands.
REQ-015 A MUL with a = 0 or b = 0 SHALL still take WIDTH+1 cycles, with no early termination.

Reset
REQ-016 Asserting reset SHALL immediately force:
- FSM = IDLE
- in_ready = 1 after reset releases
- out_valid = 0, result = 0, zero = 1
- multiply counter and accumulator = 0
REQ-017 A reset during BUSY or DONE SHALL abort the operation with no result delivered; the first edge after deassertion may accept a new op.

Structure
REQ-018 A shared package alu_pkg SHALL hold the alu_op encoding constants and the FSM state enum (IDLE, BUSY, DONE).
REQ-019 The iterative multiplier SHALL be one sub-module, alu_mul_iter, with start/done handshake, WIDTH parameter, clk and reset.
REQ-020 The single-cycle ops SHALL stay in the alu_mc top.

Verification (WIDTH=64)
REQ-021 ADD: a=5, b=7, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0; in_ready high again the following cycle.
REQ-022 SUB and wrap: a=3, b=3 -> result=0, zero=1; a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, zero=0.
REQ-023 Shifts: a=0x8000_0000_0000_0000, b=0x41 (amount 1):
- SRL -> 0x4000_0000_0000_0000
- SRA -> 0xC000_0000_0000_0000
- SLL with a=1, b=63 -> 0x8000_0000_0000_0000
REQ-024 MUL: a=0x1_0000_0001, b=0x1_0000_0003 -> out_valid exactly 65 cycles after accept, result=0x4_0000_0003; in_valid pulses during BUSY are ignored (in_ready=0).
REQ-025 Backpressure and illegal op: alu_op=0100 with out_ready held 0 for 10 cycles -> result=0, zero=1 held stable and out_valid high for all 10 cycles; IDLE reached one edge after out_ready rises.
REQ-026 Reset mid-MUL: assert reset 20 cycles into BUSY -> out_valid=0 and result=0 immediately; after release, ADD a=1, b=1 -> result=2 one cycle after accept.
